branch_target_buffer: RTL

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. Fetch looks up the current PC combinationally, so the
// prediction is available in the same cycle. Execute trains the table with
// resolved branches, and those updates land on the rising clock edge.
//
// Parameters
//   ENTRIES              number of entries (power of two, 2..64)
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-high reset; clears all state
//   pc                   fetch PC to look up
//   btb_pc_valid         lookup hit (valid and tag match)
//   btb_pc_predictTaken  hit and counter MSB set
//   branch_target_pc     stored target on hit, zero on miss
//   upd_en               resolved-branch update strobe
//   upd_pc               PC of the resolved branch
//   upd_taken            resolved direction
//   upd_target           resolved target address
//   btb_flush            invalidate every entry; overrides a concurrent update
// ---------------------------------------------------------------------------
module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        btb_pc_valid,
    output logic        btb_pc_predictTaken,
    output logic [31:0] branch_target_pc,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        btb_flush
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    if ((ENTRIES < 2) || (ENTRIES > 64) || ((1 << IDX_W) != ENTRIES)) begin : g_bad_entries
        $error("branch_target_buffer: ENTRIES must be a power of two in 2..64");
    end

    // Counter encodings
    localparam logic [1:0] CtrStrongNt = 2'b00;
    localparam logic [1:0] CtrWeakT    = 2'b10;
    localparam logic [1:0] CtrStrongT  = 2'b11;

    // -----------------------------------------------------------------------
    // Storage. Packed arrays allow a single-statement clear on reset and flush.
    // -----------------------------------------------------------------------
    logic [ENTRIES-1:0]             valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
    logic [ENTRIES-1:0][31:0]       target_q;
    logic [ENTRIES-1:0][1:0]        ctr_q;

    // The byte offset within a word never takes part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc[1:0], upd_pc[1:0]};

    // -----------------------------------------------------------------------
    // Lookup: purely combinational from the stored state
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;

    assign rd_idx = pc[IDX_W+1:2];
    assign rd_tag = pc[31:IDX_W+2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    assign btb_pc_valid        = rd_hit;
    assign btb_pc_predictTaken = rd_hit && ctr_q[rd_idx][1];
    assign branch_target_pc    = rd_hit ? target_q[rd_idx] : 32'h0;

    // -----------------------------------------------------------------------
    // Update: next-state of the single entry addressed by upd_pc
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       upd_ctr_cur;
    logic             entry_we;
    logic [1:0]       ctr_d;
    logic [31:0]      target_d;

    assign upd_idx     = upd_pc[IDX_W+1:2];
    assign upd_tag     = upd_pc[31:IDX_W+2];
    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_ctr_cur = ctr_q[upd_idx];

    always_comb begin
        entry_we = 1'b0;
        ctr_d    = upd_ctr_cur;
        target_d = target_q[upd_idx];
        if (upd_en && !btb_flush) begin
            if (upd_hit) begin
                entry_we = 1'b1;
                if (upd_taken) begin
                    ctr_d    = (upd_ctr_cur == CtrStrongT) ? upd_ctr_cur : upd_ctr_cur + 2'd1;
                    target_d = upd_target;
                end else begin
                    ctr_d    = (upd_ctr_cur == CtrStrongNt) ? upd_ctr_cur : upd_ctr_cur - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocate on a taken miss, evicting whatever lived here.
                entry_we = 1'b1;
                ctr_d    = CtrWeakT;
                target_d = upd_target;
            end
            // A not-taken miss leaves the table untouched.
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= '0;
        end else if (btb_flush) begin
            // Only valid bits are cleared; stale payload is harmless.
            valid_q <= '0;
        end else if (entry_we) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= target_d;
            ctr_q[upd_idx]    <= ctr_d;
        end
    end

endmodule
